addex_sched: RTL and testbench



---
 rtl/addex_sched.sv | 132 +++++++++++++
 tb/tb_addex_sched.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/addex_sched.sv
// Two-requester round-robin scheduler around one shared addex adder.
// The sum and the winner's ID go into a single output stage with a valid/ready handoff.

module addex (
  input  logic [3:0] a,
  input  logic [2:0] b,
  output logic [3:0] q
);
  // Sum modulo 16: the carry out is discarded.
  assign q = a + 4'(b);
endmodule

module addex_sched #(
  parameter int unsigned CNTW = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req0_valid,
  input  logic [3:0]      req0_a,
  input  logic [2:0]      req0_b,
  output logic            req0_ready,
  input  logic            req1_valid,
  input  logic [3:0]      req1_a,
  input  logic [2:0]      req1_b,
  output logic            req1_ready,
  output logic            res_valid,
  output logic [3:0]      res_q,
  output logic            res_id,
  input  logic            res_ready,
  output logic [CNTW-1:0] done_cnt
);

  localparam int unsigned AW = 4;
  localparam int unsigned BW = 3;

  typedef enum logic [0:0] {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } stage_t;

  stage_t          st_q;
  stage_t          st_nxt;
  logic            prio_q;
  logic [AW-1:0]   q_q;
  logic            id_q;
  logic [CNTW-1:0] cnt_q;

  logic            grant0;
  logic            grant1;
  logic            slot_free;
  logic            accept;
  logic            handoff;
  logic            sel;
  logic [AW-1:0]   add_a;
  logic [BW-1:0]   add_b;
  logic [AW-1:0]   add_q;

  // Grant, slot availability and next-stage decode.
  always_comb begin
    grant0    = 1'b0;
    grant1    = 1'b0;
    slot_free = 1'b0;
    accept    = 1'b0;
    handoff   = 1'b0;
    sel       = 1'b0;
    st_nxt    = st_q;

    grant0    = req0_valid & (~req1_valid | ~prio_q);
    grant1    = req1_valid & (~req0_valid |  prio_q);
    slot_free = (st_q == EMPTY) | res_ready;
    accept    = (grant0 | grant1) & slot_free & ~rst;
    handoff   = (st_q == FULL) & res_ready;
    sel       = grant1;

    if (accept) begin
      st_nxt = FULL;
    end else if (res_ready) begin
      st_nxt = EMPTY;
    end
  end

  // Shared adder operand mux.
  always_comb begin
    add_a = req0_a;
    add_b = req0_b;
    if (sel) begin
      add_a = req1_a;
      add_b = req1_b;
    end
  end

  addex u_addex (
    .a (add_a),
    .b (add_b),
    .q (add_q)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      st_q <= EMPTY;
    end else begin
      st_q <= st_nxt;
    end
  end

  // Result payload, priority pointer and handoff counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      q_q    <= '0;
      id_q   <= 1'b0;
      prio_q <= 1'b0;
      cnt_q  <= '0;
    end else begin
      if (accept) begin
        q_q    <= add_q;
        id_q   <= sel;
        prio_q <= ~sel;
      end
      if (handoff) begin
        cnt_q <= cnt_q + CNTW'(1);
      end
    end
  end

  assign req0_ready = grant0 & slot_free & ~rst;
  assign req1_ready = grant1 & slot_free & ~rst;
  assign res_valid  = (st_q == FULL);
  assign res_q      = q_q;
  assign res_id     = id_q;
  assign done_cnt   = cnt_q;

endmodule

// File: tb/tb_addex_sched.sv
// Bench for addex_sched: directed vector table, multi-cycle corner sequences,
// then random traffic against a rule-level reference model.

module tb_addex_sched;

  localparam int unsigned CNTW = 2;

  logic            clk;
  logic            rst;
  logic            req0_valid;
  logic [3:0]      req0_a;
  logic [2:0]      req0_b;
  logic            req0_ready;
  logic            req1_valid;
  logic [3:0]      req1_a;
  logic [2:0]      req1_b;
  logic            req1_ready;
  logic            res_valid;
  logic [3:0]      res_q;
  logic            res_id;
  logic            res_ready;
  logic [CNTW-1:0] done_cnt;

  int checks;
  int failures;

  addex_sched #(.CNTW(CNTW)) dut (
    .clk        (clk),
    .rst        (rst),
    .req0_valid (req0_valid),
    .req0_a     (req0_a),
    .req0_b     (req0_b),
    .req0_ready (req0_ready),
    .req1_valid (req1_valid),
    .req1_a     (req1_a),
    .req1_b     (req1_b),
    .req1_ready (req1_ready),
    .res_valid  (res_valid),
    .res_q      (res_q),
    .res_id     (res_id),
    .res_ready  (res_ready),
    .done_cnt   (done_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  typedef struct {
    logic       r0v;
    logic [3:0] a0;
    logic [2:0] b0;
    logic       r1v;
    logic [3:0] a1;
    logic [2:0] b1;
    logic       rr;
    logic       e0;
    logic       e1;
    logic       ev;
    logic [3:0] eq;
    logic       eid;
    logic [1:0] ecnt;
  } vec_t;

  vec_t tbl[15];

  function automatic vec_t mk(input logic r0v, input logic [3:0] a0, input logic [2:0] b0,
                              input logic r1v, input logic [3:0] a1, input logic [2:0] b1,
                              input logic rr, input logic e0, input logic e1,
                              input logic ev, input logic [3:0] eq, input logic eid,
                              input logic [1:0] ecnt);
    vec_t v;
    v.r0v = r0v; v.a0 = a0; v.b0 = b0;
    v.r1v = r1v; v.a1 = a1; v.b1 = b1;
    v.rr = rr; v.e0 = e0; v.e1 = e1;
    v.ev = ev; v.eq = eq; v.eid = eid; v.ecnt = ecnt;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
    end
  endtask

  task automatic drive(input logic r0v, input logic [3:0] a0, input logic [2:0] b0,
                       input logic r1v, input logic [3:0] a1, input logic [2:0] b1,
                       input logic rr);
    req0_valid = r0v; req0_a = a0; req0_b = b0;
    req1_valid = r1v; req1_a = a1; req1_b = b1;
    res_ready  = rr;
  endtask

  // Called #1 after a rising edge; leaves time at #1 after the next rising edge.
  task automatic do_reset(input int ncyc);
    rst = 1'b1;
    drive(1'b1, 4'h1, 3'd1, 1'b1, 4'h4, 3'd3, 1'b1);
    for (int i = 0; i < ncyc; i++) begin
      #3;
      chk("rst_req0_ready", 32'(req0_ready), 32'd0);
      chk("rst_req1_ready", 32'(req1_ready), 32'd0);
      @(posedge clk); #1;
    end
    chk("rst_res_valid", 32'(res_valid), 32'd0);
    chk("rst_res_q",     32'(res_q),     32'd0);
    chk("rst_res_id",    32'(res_id),    32'd0);
    chk("rst_done_cnt",  32'(done_cnt),  32'd0);
    rst = 1'b0;
  endtask

  // Reference model state
  logic       m_v;
  logic [3:0] m_q;
  logic       m_id;
  logic       m_prio;
  int         m_cnt;
  logic       p0, p1;
  logic [3:0] pa0, pa1;
  logic [2:0] pb0, pb1;

  initial begin
    checks = 0;
    failures = 0;
    rst = 1'b1;
    drive(1'b0, 4'h0, 3'd0, 1'b0, 4'h0, 3'd0, 1'b0);

    //           r0v a0    b0    r1v a1    b1    rr    e0    e1    ev    eq     id    cnt
    tbl[0]  = mk(1, 4'h1, 3'd1, 1, 4'h4, 3'd3, 1'b1, 1'b1, 1'b0, 1'b1, 4'd2, 1'b0, 2'd0);
    tbl[1]  = mk(1, 4'h1, 3'd1, 1, 4'h4, 3'd3, 1'b1, 1'b0, 1'b1, 1'b1, 4'd7, 1'b1, 2'd1);
    tbl[2]  = mk(1, 4'h1, 3'd1, 1, 4'h4, 3'd3, 1'b1, 1'b1, 1'b0, 1'b1, 4'd2, 1'b0, 2'd2);
    tbl[3]  = mk(1, 4'h1, 3'd1, 1, 4'h4, 3'd3, 1'b1, 1'b0, 1'b1, 1'b1, 4'd7, 1'b1, 2'd3);
    tbl[4]  = mk(1, 4'h3, 3'd2, 0, 4'h0, 3'd0, 1'b1, 1'b1, 1'b0, 1'b1, 4'd5, 1'b0, 2'd0);
    tbl[5]  = mk(1, 4'hF, 3'd7, 0, 4'h0, 3'd0, 1'b1, 1'b1, 1'b0, 1'b1, 4'd6, 1'b0, 2'd1);
    tbl[6]  = mk(1, 4'h8, 3'd0, 0, 4'h0, 3'd0, 1'b1, 1'b1, 1'b0, 1'b1, 4'd8, 1'b0, 2'd2);
    tbl[7]  = mk(0, 4'h0, 3'd0, 0, 4'h0, 3'd0, 1'b1, 1'b0, 1'b0, 1'b0, 4'd8, 1'b0, 2'd3);
    tbl[8]  = mk(0, 4'h0, 3'd0, 0, 4'h0, 3'd0, 1'b1, 1'b0, 1'b0, 1'b0, 4'd8, 1'b0, 2'd3);
    tbl[9]  = mk(1, 4'h2, 3'd3, 0, 4'h0, 3'd0, 1'b0, 1'b1, 1'b0, 1'b1, 4'd5, 1'b0, 2'd3);
    tbl[10] = mk(0, 4'h0, 3'd0, 1, 4'h6, 3'd1, 1'b0, 1'b0, 1'b0, 1'b1, 4'd5, 1'b0, 2'd3);
    tbl[11] = mk(0, 4'h0, 3'd0, 1, 4'h6, 3'd1, 1'b0, 1'b0, 1'b0, 1'b1, 4'd5, 1'b0, 2'd3);
    tbl[12] = mk(0, 4'h0, 3'd0, 1, 4'h6, 3'd1, 1'b0, 1'b0, 1'b0, 1'b1, 4'd5, 1'b0, 2'd3);
    tbl[13] = mk(0, 4'h0, 3'd0, 1, 4'h6, 3'd1, 1'b1, 1'b0, 1'b1, 1'b1, 4'd7, 1'b1, 2'd0);
    tbl[14] = mk(0, 4'h0, 3'd0, 0, 4'h0, 3'd0, 1'b1, 1'b0, 1'b0, 1'b0, 4'd7, 1'b1, 2'd1);

    @(posedge clk); #1;
    do_reset(2);

    // Directed table: contention, single requester wrap, idle, backpressure
    for (int i = 0; i < 15; i++) begin
      drive(tbl[i].r0v, tbl[i].a0, tbl[i].b0, tbl[i].r1v, tbl[i].a1, tbl[i].b1, tbl[i].rr);
      #3;
      chk($sformatf("v%0d_req0_ready", i), 32'(req0_ready), 32'(tbl[i].e0));
      chk($sformatf("v%0d_req1_ready", i), 32'(req1_ready), 32'(tbl[i].e1));
      @(posedge clk); #1;
      chk($sformatf("v%0d_res_valid", i), 32'(res_valid), 32'(tbl[i].ev));
      chk($sformatf("v%0d_res_q", i),     32'(res_q),     32'(tbl[i].eq));
      chk($sformatf("v%0d_res_id", i),    32'(res_id),    32'(tbl[i].eid));
      chk($sformatf("v%0d_done_cnt", i),  32'(done_cnt),  32'(tbl[i].ecnt));
    end

    // Reset while FULL: held 9 is discarded uncounted and prio returns to 0
    drive(1'b1, 4'h5, 3'd4, 1'b0, 4'h0, 3'd0, 1'b0);
    @(posedge clk); #1;
    chk("mid_load_q", 32'(res_q), 32'd9);
    chk("mid_load_valid", 32'(res_valid), 32'd1);
    rst = 1'b1;
    res_ready = 1'b1;
    #3;
    chk("mid_rst_req0_ready", 32'(req0_ready), 32'd0);
    @(posedge clk); #1;
    chk("mid_rst_valid", 32'(res_valid), 32'd0);
    chk("mid_rst_q",     32'(res_q),     32'd0);
    chk("mid_rst_cnt",   32'(done_cnt),  32'd0);
    rst = 1'b0;
    drive(1'b1, 4'h1, 3'd1, 1'b1, 4'h4, 3'd3, 1'b1);
    #3;
    chk("mid_prio_req0_ready", 32'(req0_ready), 32'd1);
    chk("mid_prio_req1_ready", 32'(req1_ready), 32'd0);
    @(posedge clk); #1;
    chk("mid_after_id", 32'(res_id), 32'd0);

    // Random traffic against the reference model
    do_reset(1);
    m_v = 1'b0; m_q = 4'd0; m_id = 1'b0; m_prio = 1'b0; m_cnt = 0;
    p0 = 1'b0; p1 = 1'b0; pa0 = '0; pa1 = '0; pb0 = '0; pb1 = '0;
    for (int c = 0; c < 2000; c++) begin
      logic rr, g0, g1, sf, acc, win;
      logic [3:0] sum;
      if (!p0 && ($urandom_range(0, 3) != 0)) begin
        p0 = 1'b1; pa0 = 4'($urandom_range(0, 15)); pb0 = 3'($urandom_range(0, 7));
      end
      if (!p1 && ($urandom_range(0, 3) != 0)) begin
        p1 = 1'b1; pa1 = 4'($urandom_range(0, 15)); pb1 = 3'($urandom_range(0, 7));
      end
      rr = ($urandom_range(0, 2) != 0);
      drive(p0, pa0, pb0, p1, pa1, pb1, rr);

      sf  = !m_v || rr;
      g0  = p0 && (!p1 || (m_prio == 1'b0));
      g1  = p1 && (!p0 || (m_prio == 1'b1));
      acc = sf && (g0 || g1);
      #3;
      chk("rnd_req0_ready", 32'(req0_ready), 32'(g0 && sf));
      chk("rnd_req1_ready", 32'(req1_ready), 32'(g1 && sf));

      if (m_v && rr) m_cnt = (m_cnt + 1) % (1 << CNTW);
      if (acc) begin
        win = g1;
        sum = win ? 4'((int'(pa1) + int'(pb1)) % 16) : 4'((int'(pa0) + int'(pb0)) % 16);
        m_q = sum; m_id = win; m_v = 1'b1; m_prio = !win;
        if (win) p1 = 1'b0; else p0 = 1'b0;
      end else if (rr) begin
        m_v = 1'b0;
      end
      @(posedge clk); #1;
      chk("rnd_res_valid", 32'(res_valid), 32'(m_v));
      chk("rnd_res_q",     32'(res_q),     32'(m_q));
      chk("rnd_res_id",    32'(res_id),    32'(m_id));
      chk("rnd_done_cnt",  32'(done_cnt),  32'(m_cnt));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
